branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor feeding the fetch stage: a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. It is looked up combinationally with the current fetch `pc` and drives `branch_prediction` / `pc_target_prediction` into fetch in the same cycle. The resolved outcome from the address builder (execute stage) updates it on `stage_clk`. It also keeps a mispredict counter for performance measurement.

## Interface
- `ENTRIES`, 16: number of BTB entries; must be a power of two, minimum 2.
- `IDX_W`, $clog2(ENTRIES): index width, derived; not overridden.
- `stage_clk`  in  1  stage clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  32  current fetch PC (lookup address).
- `branch_prediction`  out  1  1 = predict taken for `pc`.
- `pc_target_prediction`  out  32  predicted next PC: BTB target on a taken prediction, else `pc + 4`.
- `upd_valid`  in  1  a resolved branch is presented this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  real outcome (`flag_real_branch`).
- `upd_target`  in  32  real target (`pc_real_target`).
- `upd_predicted`  in  1  prediction that was made for this branch, as propagated down the pipeline.
- `bp_clear`  in  1  synchronous invalidate of all entries.
- `mispredict_cnt`  out  32  count of updates where `upd_predicted != upd_taken`.

## Operation
- Entry fields: `valid` (1), `tag` (32-IDX_W-2), `target` (32), `ctr` (2).
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`. Bits [1:0] are ignored.
- Lookup is purely combinational from registered state. `hit = valid && tag match`.
- `branch_prediction = hit && ctr[1]`.
- `pc_target_prediction = branch_prediction ? target : pc + 4`. The addition wraps modulo 2^32.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Counter updates saturate: increments at 11 stay 11; decrements at 00 stay 00.
- Update rules when `upd_valid`=1, using index and tag of `upd_pc`:
  - Hit and taken: increment `ctr` and write `target <= upd_target`.
  - Hit and not taken: decrement `ctr`; `target` is unchanged.
  - Miss and taken: allocate the entry, replacing any previous occupant. Set `valid=1`, tag, `target=upd_target`, `ctr=10`.
  - Miss and not taken: no change.
- `mispredict_cnt` increments by 1 when `upd_valid && (upd_predicted != upd_taken)`. It wraps from 0xFFFFFFFF to 0.
- `bp_clear`=1 clears every `valid` bit at the edge and takes priority over a simultaneous update. `ctr`, `target` and `mispredict_cnt` are unaffected.

## Timing
- Reset values: all `valid`=0, `ctr`=01, `target`=0, `tag`=0, `mispredict_cnt`=0.
- After reset, `branch_prediction`=0 and `pc_target_prediction`=`pc+4`.
- Lookup latency is zero cycles (combinational, same cycle as `pc`).
- An update is visible to lookups from the cycle after the edge that samples it.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents.
- Reset asserted mid-operation clears state immediately, independent of the clock. Outputs return to their reset values within the same cycle.
- Two different PCs aliasing to one index: the later taken allocation evicts the earlier entry. The tag check prevents false hits.

## Structure
- Shared package `bp_pkg`:
  - `ENTRIES_DEFAULT`
  - counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`
  - `ctr_t` typedef
  - the BTB entry struct typedef
- One sub-module, `bp_sat_counter`: a combinational 2-bit saturating next-value function with inputs `ctr`, `inc`, `dec`. It is instantiated once on the update path.
- Storage is register arrays, not inferred RAM, because the lookup read is asynchronous.

## Test plan
- **Reset:** assert `reset`, drive `pc`=0x100 -> `branch_prediction`=0, `pc_target_prediction`=0x104, `mispredict_cnt`=0.
- **Allocate:** update `upd_pc`=0x40, taken, `upd_target`=0x200, `upd_predicted`=0. Next cycle `pc`=0x40 -> prediction 1, target 0x200; `mispredict_cnt`=1.
- **Saturation:** after allocating 0x40, apply three not-taken updates -> `ctr` goes 10 -> 01 -> 00 -> 00. `pc`=0x40 predicts 0 with target 0x44. Two taken updates then bring the prediction back to 1.
- **Alias and same-cycle update:** allocate 0x40, then allocate 0x80 (same index with ENTRIES=16), target 0x300 -> `pc`=0x40 misses (0, 0x44) and `pc`=0x80 hits (0x300). A lookup in the same cycle as the 0x80 update sees the old 0x40 entry.
- **Clear and counter wrap:** `bp_clear` together with a taken update to 0x40 -> no entry valid afterwards. Force `mispredict_cnt`=0xFFFFFFFF, then one mispredicting update -> 0.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch predictor: the default BTB depth,
// the 2-bit direction counter encodings, and the BTB entry layout.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int ENTRIES_DEFAULT = 16;

    // The tag is pc[31:IDX_W+2]. The smallest legal table has two entries,
    // which gives the widest tag (29 bits). Narrower tags from larger tables
    // are zero-extended into this field, so one entry layout fits every depth.
    localparam int TAG_W_MAX = 29;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;   // strongly not-taken
    localparam ctr_t CTR_WNT = 2'b01;   // weakly not-taken
    localparam ctr_t CTR_WT  = 2'b10;   // weakly taken
    localparam ctr_t CTR_ST  = 2'b11;   // strongly taken

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } bp_entry_t;

    // The upper counter bit is the taken/not-taken direction.
    function automatic logic ctr_predicts_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Combinational next value of a 2-bit saturating direction counter.
//   ctr      in  2  current counter value
//   inc      in  1  step towards strongly taken (holds at CTR_ST)
//   dec      in  1  step towards strongly not-taken (holds at CTR_SNT)
//   ctr_next out 2  counter value after the step
// If inc and dec are both asserted, the counter holds its value.
// ---------------------------------------------------------------------------
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic inc,
    input  logic dec,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc && !dec) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else if (dec && !inc) begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. The fetch PC is looked up combinationally and the
// prediction is returned to fetch in the same cycle. Resolved branches from
// the execute stage train the table on the rising edge of stage_clk. A
// free-running mispredict counter supports performance measurement.
//
// Ports
//   stage_clk             in  1   stage clock, rising-edge
//   reset                 in  1   asynchronous, active-high
//   pc                    in  32  fetch PC to look up
//   branch_prediction     out 1   1 = predict taken for pc
//   pc_target_prediction  out 32  BTB target when predicted taken, else pc+4
//   upd_valid             in  1   a resolved branch is presented this cycle
//   upd_pc                in  32  PC of the resolved branch
//   upd_taken             in  1   actual direction of the branch
//   upd_target            in  32  actual target of the branch
//   upd_predicted         in  1   direction predicted for it at fetch time
//   bp_clear              in  1   synchronous invalidate of all entries
//   mispredict_cnt        out 32  number of updates with a wrong prediction
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic        stage_clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        branch_prediction,
    output logic [31:0] pc_target_prediction,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_predicted,
    input  logic        bp_clear,
    output logic [31:0] mispredict_cnt
);

    bp_entry_t r_btb [ENTRIES];
    logic [31:0] r_mispredict_cnt;

    // ------------------------------------------------------------------
    // Lookup path (combinational from registered state)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     w_rd_idx;
    logic [TAG_W_MAX-1:0] w_rd_tag;
    bp_entry_t            w_rd_entry;
    logic                 w_rd_hit;
    logic                 w_predict_taken;

    assign w_rd_idx   = pc[IDX_W+1:2];
    assign w_rd_tag   = TAG_W_MAX'(pc[31:IDX_W+2]);
    assign w_rd_entry = r_btb[w_rd_idx];
    assign w_rd_hit   = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);

    assign w_predict_taken      = w_rd_hit && ctr_predicts_taken(w_rd_entry.ctr);
    assign branch_prediction    = w_predict_taken;
    assign pc_target_prediction = w_predict_taken ? w_rd_entry.target : (pc + 32'd4);

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     w_upd_idx;
    logic [TAG_W_MAX-1:0] w_upd_tag;
    bp_entry_t            w_upd_entry;
    logic                 w_upd_hit;
    logic                 w_ctr_inc;
    logic                 w_ctr_dec;
    ctr_t                 w_ctr_next;
    logic                 w_mispredict;

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = TAG_W_MAX'(upd_pc[31:IDX_W+2]);
    assign w_upd_entry = r_btb[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    // Only a hit trains the counter; a taken miss allocates with CTR_WT.
    assign w_ctr_inc = upd_valid && w_upd_hit && upd_taken;
    assign w_ctr_dec = upd_valid && w_upd_hit && !upd_taken;

    assign w_mispredict = upd_valid && (upd_predicted != upd_taken);

    bp_sat_counter u_sat_counter (
        .ctr      (w_upd_entry.ctr),
        .inc      (w_ctr_inc),
        .dec      (w_ctr_dec),
        .ctr_next (w_ctr_next)
    );

    // Clear only drops valid bits; counters and targets are kept so the
    // reset values stay meaningful only after a real reset.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid  <= 1'b0;
                r_btb[i].tag    <= '0;
                r_btb[i].target <= '0;
                r_btb[i].ctr    <= CTR_WNT;
            end
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                r_btb[w_upd_idx].ctr <= w_ctr_next;
                if (upd_taken) begin
                    r_btb[w_upd_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                r_btb[w_upd_idx].valid  <= 1'b1;
                r_btb[w_upd_idx].tag    <= w_upd_tag;
                r_btb[w_upd_idx].target <= upd_target;
                r_btb[w_upd_idx].ctr    <= CTR_WT;
            end
        end
    end

    // Counts mispredictions independently of bp_clear; wraps at 2^32.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            r_mispredict_cnt <= '0;
        end else if (w_mispredict) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign mispredict_cnt = r_mispredict_cnt;

    // Byte-offset bits of the PCs play no part in indexing or tagging.
    logic w_unused;
    assign w_unused = &{1'b0, pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed self-checking bench for branch_predictor (ENTRIES = 16, so the
// index is pc[5:2]; 0x40, 0x80 and 0xC0 all share index 0 with tags 1/2/3).
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        stage_clk;
    logic        reset;
    logic [31:0] pc;
    logic        branch_prediction;
    logic [31:0] pc_target_prediction;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_predicted;
    logic        bp_clear;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .stage_clk            (stage_clk),
        .reset                (reset),
        .pc                   (pc),
        .branch_prediction    (branch_prediction),
        .pc_target_prediction (pc_target_prediction),
        .upd_valid            (upd_valid),
        .upd_pc               (upd_pc),
        .upd_taken            (upd_taken),
        .upd_target           (upd_target),
        .upd_predicted        (upd_predicted),
        .bp_clear             (bp_clear),
        .mispredict_cnt       (mispredict_cnt)
    );

    initial stage_clk = 1'b0;
    always #5 stage_clk = ~stage_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] p, input logic tk,
                           input logic [31:0] tgt, input logic pred);
        upd_valid     = 1'b1;
        upd_pc        = p;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_predicted = pred;
    endtask

    // One clock edge, then back on the falling edge with the update removed.
    task automatic step();
        @(posedge stage_clk);
        @(negedge stage_clk);
        upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] p);
        pc = p;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        pc            = 32'h100;
        upd_valid     = 1'b0;
        upd_pc        = '0;
        upd_taken     = 1'b0;
        upd_target    = '0;
        upd_predicted = 1'b0;
        bp_clear      = 1'b0;
        #1;
        check("reset_bp",  {31'd0, branch_prediction}, 32'd0);
        check("reset_tgt", pc_target_prediction, 32'h104);
        check("reset_cnt", mispredict_cnt, 32'd0);

        @(negedge stage_clk);
        @(negedge stage_clk);
        reset = 1'b0;

        // Allocate 0x40; lookup in the same cycle still misses.
        set_upd(32'h40, 1'b1, 32'h200, 1'b0);
        look(32'h40);
        check("alloc_same_cycle_bp",  {31'd0, branch_prediction}, 32'd0);
        check("alloc_same_cycle_tgt", pc_target_prediction, 32'h44);
        step();
        look(32'h40);
        check("alloc_bp",  {31'd0, branch_prediction}, 32'd1);
        check("alloc_tgt", pc_target_prediction, 32'h200);
        check("alloc_cnt", mispredict_cnt, 32'd1);

        // Three not-taken: 10 -> 01 -> 00 -> 00.
        set_upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b1);
        step();
        look(32'h40);
        check("nt1_bp",  {31'd0, branch_prediction}, 32'd0);
        check("nt1_tgt", pc_target_prediction, 32'h44);
        check("nt1_cnt", mispredict_cnt, 32'd2);
        set_upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b1);
        step();
        set_upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b1);
        step();
        look(32'h40);
        check("nt3_bp",  {31'd0, branch_prediction}, 32'd0);
        check("nt3_cnt", mispredict_cnt, 32'd4);

        // Two taken from 00: 00 -> 01 (still not taken) -> 10.
        set_upd(32'h40, 1'b1, 32'h200, 1'b0);
        step();
        look(32'h40);
        check("t1_bp",  {31'd0, branch_prediction}, 32'd0);
        check("t1_tgt", pc_target_prediction, 32'h44);
        set_upd(32'h40, 1'b1, 32'h240, 1'b0);
        step();
        look(32'h40);
        check("t2_bp",  {31'd0, branch_prediction}, 32'd1);
        check("t2_tgt", pc_target_prediction, 32'h240);
        check("t2_cnt", mispredict_cnt, 32'd6);

        // Upper saturation: 10 -> 11 -> 11, then 11 -> 10 -> 01.
        set_upd(32'h40, 1'b1, 32'h240, 1'b1);
        step();
        set_upd(32'h40, 1'b1, 32'h240, 1'b1);
        step();
        look(32'h40);
        check("sat_hi_cnt", mispredict_cnt, 32'd6);
        set_upd(32'h40, 1'b0, 32'h0000_BAD0, 1'b1);
        step();
        look(32'h40);
        check("dec_from_st_bp",  {31'd0, branch_prediction}, 32'd1);
        check("dec_keeps_tgt",   pc_target_prediction, 32'h240);
        check("dec_from_st_cnt", mispredict_cnt, 32'd7);
        set_upd(32'h40, 1'b0, 32'h0000_BAD0, 1'b1);
        step();
        look(32'h40);
        check("dec_to_wnt_bp",  {31'd0, branch_prediction}, 32'd0);
        check("dec_to_wnt_tgt", pc_target_prediction, 32'h44);

        // Raise 0x40 back to 10 with target 0x200.
        set_upd(32'h40, 1'b1, 32'h200, 1'b0);
        step();
        look(32'h40);
        check("reraise_bp",  {31'd0, branch_prediction}, 32'd1);
        check("reraise_tgt", pc_target_prediction, 32'h200);
        check("reraise_cnt", mispredict_cnt, 32'd9);

        // 0x80 aliases index 0; same-cycle lookup sees the old 0x40 entry.
        set_upd(32'h80, 1'b1, 32'h300, 1'b0);
        look(32'h40);
        check("alias_same_cycle_bp",  {31'd0, branch_prediction}, 32'd1);
        check("alias_same_cycle_tgt", pc_target_prediction, 32'h200);
        step();
        look(32'h40);
        check("alias_old_bp",  {31'd0, branch_prediction}, 32'd0);
        check("alias_old_tgt", pc_target_prediction, 32'h44);
        look(32'h80);
        check("alias_new_bp",  {31'd0, branch_prediction}, 32'd1);
        check("alias_new_tgt", pc_target_prediction, 32'h300);
        check("alias_cnt", mispredict_cnt, 32'd10);

        // Miss + not taken leaves the table alone.
        set_upd(32'hC0, 1'b0, 32'h500, 1'b0);
        step();
        look(32'hC0);
        check("miss_nt_bp",  {31'd0, branch_prediction}, 32'd0);
        check("miss_nt_tgt", pc_target_prediction, 32'hC4);
        look(32'h80);
        check("miss_nt_keep_tgt", pc_target_prediction, 32'h300);
        check("miss_nt_cnt", mispredict_cnt, 32'd10);
        look(32'h44);
        check("other_idx_tgt", pc_target_prediction, 32'h48);
        look(32'hFFFF_FFFC);
        check("pc_wrap_tgt", pc_target_prediction, 32'h0);

        // Clear wins over a simultaneous taken update.
        bp_clear = 1'b1;
        set_upd(32'h40, 1'b1, 32'h600, 1'b1);
        step();
        bp_clear = 1'b0;
        look(32'h40);
        check("clear_40_bp",  {31'd0, branch_prediction}, 32'd0);
        check("clear_40_tgt", pc_target_prediction, 32'h44);
        look(32'h80);
        check("clear_80_tgt", pc_target_prediction, 32'h84);
        check("clear_cnt", mispredict_cnt, 32'd10);

        // Counter wrap.
        force dut.r_mispredict_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_mispredict_cnt;
        #1;
        check("cnt_preset", mispredict_cnt, 32'hFFFF_FFFF);
        set_upd(32'h100, 1'b0, 32'h0, 1'b1);
        step();
        #1;
        check("cnt_wrap", mispredict_cnt, 32'd0);

        // Asynchronous reset mid-operation.
        set_upd(32'h40, 1'b1, 32'h700, 1'b0);
        step();
        look(32'h40);
        check("pre_areset_tgt", pc_target_prediction, 32'h700);
        check("pre_areset_cnt", mispredict_cnt, 32'd1);
        reset = 1'b1;
        #1;
        check("areset_bp",  {31'd0, branch_prediction}, 32'd0);
        check("areset_tgt", pc_target_prediction, 32'h44);
        check("areset_cnt", mispredict_cnt, 32'd0);
        @(negedge stage_clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
